// File: rtl/nn_pkg.sv
// Shared types and constants for the nn_node host-side driver.
// Word indices follow the serial load order of the operand stream.
package nn_pkg;

   localparam int DW     = 16;
   localparam int N_X    = 4;
   localparam int N_W    = 24;
   localparam int NWORDS = N_X + N_W;
   localparam int IDXW   = $clog2(NWORDS);

   typedef logic [DW-1:0] word_t;

   typedef enum logic [1:0] {
      LOAD,
      FIRE,
      WAIT,
      RESULT
   } drv_state_e;

   localparam int IDX_X0  = 0;
   localparam int IDX_X1  = 1;
   localparam int IDX_X2  = 2;
   localparam int IDX_X3  = 3;
   localparam int IDX_W04 = 4;
   localparam int IDX_W14 = 5;
   localparam int IDX_W24 = 6;
   localparam int IDX_W34 = 7;
   localparam int IDX_W05 = 8;
   localparam int IDX_W15 = 9;
   localparam int IDX_W25 = 10;
   localparam int IDX_W35 = 11;
   localparam int IDX_W06 = 12;
   localparam int IDX_W16 = 13;
   localparam int IDX_W26 = 14;
   localparam int IDX_W36 = 15;
   localparam int IDX_W07 = 16;
   localparam int IDX_W17 = 17;
   localparam int IDX_W27 = 18;
   localparam int IDX_W37 = 19;
   localparam int IDX_W48 = 20;
   localparam int IDX_W58 = 21;
   localparam int IDX_W68 = 22;
   localparam int IDX_W78 = 23;
   localparam int IDX_W49 = 24;
   localparam int IDX_W59 = 25;
   localparam int IDX_W69 = 26;
   localparam int IDX_W79 = 27;

endpackage

// File: rtl/nn_result_capture.sv
// Captures out0/out1 from nn_node on their ready strobes; the first strobe
// after a clear wins and later repeats are ignored until the next clear.
module nn_result_capture
   import nn_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_i,
   input  logic          en_i,
   input  logic          stb0_i,
   input  logic          stb1_i,
   input  logic [DW-1:0] d0_i,
   input  logic [DW-1:0] d1_i,
   output logic [DW-1:0] res0_o,
   output logic [DW-1:0] res1_o,
   output logic          both_done_o
);

   logic  cap0_q, cap1_q;
   logic  set0, set1;
   word_t res0_q, res1_q;

   assign set0 = en_i & stb0_i & ~cap0_q;
   assign set1 = en_i & stb1_i & ~cap1_q;

   // Looks through this cycle's captures so a same-cycle pair completes at once.
   assign both_done_o = (cap0_q | set0) & (cap1_q | set1);

   assign res0_o = res0_q;
   assign res1_o = res1_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap0_q <= 1'b0;
         cap1_q <= 1'b0;
         res0_q <= '0;
         res1_q <= '0;
      end else if (clr_i) begin
         cap0_q <= 1'b0;
         cap1_q <= 1'b0;
      end else begin
         if (set0) begin
            res0_q <= d0_i;
            cap0_q <= 1'b1;
         end
         if (set1) begin
            res1_q <= d1_i;
            cap1_q <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/nn_node_driver.sv
// Host-side sequencer for nn_node: loads 28 operand words serially, fires an
// inference, collects out0/out1 and hands the pair out over valid/ready.
module nn_node_driver
   import nn_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ld_valid,
   input  logic [DW-1:0] ld_data,
   output logic          ld_ready,
   output logic [DW-1:0] x0,
   output logic [DW-1:0] x1,
   output logic [DW-1:0] x2,
   output logic [DW-1:0] x3,
   output logic [DW-1:0] w04,
   output logic [DW-1:0] w14,
   output logic [DW-1:0] w24,
   output logic [DW-1:0] w34,
   output logic [DW-1:0] w05,
   output logic [DW-1:0] w15,
   output logic [DW-1:0] w25,
   output logic [DW-1:0] w35,
   output logic [DW-1:0] w06,
   output logic [DW-1:0] w16,
   output logic [DW-1:0] w26,
   output logic [DW-1:0] w36,
   output logic [DW-1:0] w07,
   output logic [DW-1:0] w17,
   output logic [DW-1:0] w27,
   output logic [DW-1:0] w37,
   output logic [DW-1:0] w48,
   output logic [DW-1:0] w58,
   output logic [DW-1:0] w68,
   output logic [DW-1:0] w78,
   output logic [DW-1:0] w49,
   output logic [DW-1:0] w59,
   output logic [DW-1:0] w69,
   output logic [DW-1:0] w79,
   output logic          in_ready,
   input  logic [DW-1:0] out0,
   input  logic [DW-1:0] out1,
   input  logic          out10_ready,
   input  logic          out11_ready,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [DW-1:0] res0,
   output logic [DW-1:0] res1,
   output logic          err_timeout
);

   localparam int CW = $clog2(TIMEOUT + 1);

   drv_state_e      state_q, state_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            err_q, err_d;
   logic            ld_ready_q, in_ready_q, res_valid_q;
   word_t           ops_q [NWORDS];

   logic  ld_acc, cap_clr, cap_en, both_done;
   word_t cap0, cap1;

   assign ld_acc = ld_valid & ld_ready_q;

   nn_result_capture u_cap (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_i       (cap_clr),
      .en_i        (cap_en),
      .stb0_i      (out10_ready),
      .stb1_i      (out11_ready),
      .d0_i        (out0),
      .d1_i        (out1),
      .res0_o      (cap0),
      .res1_o      (cap1),
      .both_done_o (both_done)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      cap_clr = 1'b0;
      cap_en  = 1'b0;
      unique case (state_q)
         LOAD: begin
            if (ld_acc) begin
               err_d = 1'b0;
               if (idx_q == IDXW'(NWORDS - 1)) begin
                  idx_d   = '0;
                  state_d = FIRE;
               end else begin
                  idx_d = idx_q + IDXW'(1);
               end
            end
         end
         FIRE: begin
            cap_clr = 1'b1;
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            cap_en = 1'b1;
            // A pair completing on the deadline cycle still wins over the abort.
            if (both_done) begin
               state_d = RESULT;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               idx_d   = '0;
               state_d = LOAD;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RESULT: begin
            if (res_valid_q && res_ready) begin
               idx_d   = '0;
               state_d = LOAD;
            end
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= LOAD;
         idx_q       <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         ld_ready_q  <= 1'b0;
         in_ready_q  <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         ld_ready_q  <= (state_d == LOAD);
         in_ready_q  <= (state_d == FIRE) || (state_d == WAIT);
         res_valid_q <= (state_d == RESULT);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NWORDS; i++) ops_q[i] <= '0;
      end else if (ld_acc) begin
         ops_q[idx_q] <= ld_data;
      end
   end

   assign ld_ready    = ld_ready_q;
   assign in_ready    = in_ready_q;
   assign res_valid   = res_valid_q;
   assign err_timeout = err_q;

   // Captured values are only exposed with res_valid, so an aborted or
   // half-finished inference never shows a partial pair.
   assign res0 = res_valid_q ? cap0 : '0;
   assign res1 = res_valid_q ? cap1 : '0;

   assign x0  = ops_q[IDX_X0];
   assign x1  = ops_q[IDX_X1];
   assign x2  = ops_q[IDX_X2];
   assign x3  = ops_q[IDX_X3];
   assign w04 = ops_q[IDX_W04];
   assign w14 = ops_q[IDX_W14];
   assign w24 = ops_q[IDX_W24];
   assign w34 = ops_q[IDX_W34];
   assign w05 = ops_q[IDX_W05];
   assign w15 = ops_q[IDX_W15];
   assign w25 = ops_q[IDX_W25];
   assign w35 = ops_q[IDX_W35];
   assign w06 = ops_q[IDX_W06];
   assign w16 = ops_q[IDX_W16];
   assign w26 = ops_q[IDX_W26];
   assign w36 = ops_q[IDX_W36];
   assign w07 = ops_q[IDX_W07];
   assign w17 = ops_q[IDX_W17];
   assign w27 = ops_q[IDX_W27];
   assign w37 = ops_q[IDX_W37];
   assign w48 = ops_q[IDX_W48];
   assign w58 = ops_q[IDX_W58];
   assign w68 = ops_q[IDX_W68];
   assign w78 = ops_q[IDX_W78];
   assign w49 = ops_q[IDX_W49];
   assign w59 = ops_q[IDX_W59];
   assign w69 = ops_q[IDX_W69];
   assign w79 = ops_q[IDX_W79];

endmodule
